// File: rtl/wb_timeout_bridge.sv
// Wishbone classic single-master/single-slave bridge that terminates unanswered slave cycles with an error.
// Optional timeout counter clear input is built when WB_TIMEOUT_CLEAR_EN is defined.
module wb_timeout_bridge #(
    parameter int unsigned TIMEOUT  = 1024,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbm_cyc_i,
    input  logic             wbm_stb_i,
    input  logic             wbm_we_i,
    input  logic [3:0]       wbm_sel_i,
    input  logic [31:0]      wbm_adr_i,
    input  logic [31:0]      wbm_dat_i,
    output logic [31:0]      wbm_dat_o,
    output logic             wbm_ack_o,
    output logic             wbm_err_o,
    output logic             wbs_cyc_o,
    output logic             wbs_stb_o,
    output logic             wbs_we_o,
    output logic [3:0]       wbs_sel_o,
    output logic [31:0]      wbs_adr_o,
    output logic [31:0]      wbs_dat_o,
    input  logic [31:0]      wbs_dat_i,
    input  logic             wbs_ack_i,
    input  logic             wbs_err_i,
`ifdef WB_TIMEOUT_CLEAR_EN
    input  logic             timeout_clr,
`endif
    output logic [CNT_W-1:0] timeout_cnt,
    output logic [31:0]      timeout_adr,
    output logic             timeout_irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 32'd1);

    state_t           state_r;
    logic [15:0]      wait_cnt_r;
    logic             clr_s;
    logic             timeout_hit_s;
    logic [CNT_W-1:0] cnt_next_s;

    // Timeout detection and next value of the saturating timeout counter
    always_comb begin
        clr_s         = 1'b0;
`ifdef WB_TIMEOUT_CLEAR_EN
        clr_s         = timeout_clr;
`endif
        timeout_hit_s = (state_r == ST_WAIT) && wbm_cyc_i && !wbs_ack_i && !wbs_err_i &&
                        (wait_cnt_r == WAIT_LAST);
        cnt_next_s    = timeout_cnt;
        if (clr_s && timeout_hit_s) begin
            cnt_next_s = CNT_W'(1'b1);
        end else if (clr_s) begin
            cnt_next_s = '0;
        end else if (timeout_hit_s && (timeout_cnt != {CNT_W{1'b1}})) begin
            cnt_next_s = timeout_cnt + CNT_W'(1'b1);
        end else begin
            cnt_next_s = timeout_cnt;
        end
    end

    // Bridge FSM with all outputs registered
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= 16'd0;
            wbm_dat_o   <= 32'd0;
            wbm_ack_o   <= 1'b0;
            wbm_err_o   <= 1'b0;
            wbs_cyc_o   <= 1'b0;
            wbs_stb_o   <= 1'b0;
            wbs_we_o    <= 1'b0;
            wbs_sel_o   <= 4'd0;
            wbs_adr_o   <= 32'd0;
            wbs_dat_o   <= 32'd0;
            timeout_cnt <= '0;
            timeout_adr <= 32'd0;
            timeout_irq <= 1'b0;
        end else begin
            wbm_ack_o   <= 1'b0;
            wbm_err_o   <= 1'b0;
            timeout_irq <= 1'b0;
            timeout_cnt <= cnt_next_s;
            case (state_r)
                ST_IDLE: begin
                    if (wbm_cyc_i && wbm_stb_i) begin
                        wbs_we_o   <= wbm_we_i;
                        wbs_sel_o  <= wbm_sel_i;
                        wbs_adr_o  <= wbm_adr_i;
                        wbs_dat_o  <= wbm_dat_i;
                        wbs_cyc_o  <= 1'b1;
                        wbs_stb_o  <= 1'b1;
                        wait_cnt_r <= 16'd0;
                        state_r    <= ST_WAIT;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // Slave error beats ack, and any slave response beats abort and timeout
                    if (wbs_err_i) begin
                        wbm_err_o <= 1'b1;
                        wbm_dat_o <= wbs_dat_i;
                        wbs_cyc_o <= 1'b0;
                        wbs_stb_o <= 1'b0;
                        state_r   <= ST_DONE;
                    end else if (wbs_ack_i) begin
                        wbm_ack_o <= 1'b1;
                        wbm_dat_o <= wbs_dat_i;
                        wbs_cyc_o <= 1'b0;
                        wbs_stb_o <= 1'b0;
                        state_r   <= ST_DONE;
                    end else if (!wbm_cyc_i) begin
                        wbs_cyc_o <= 1'b0;
                        wbs_stb_o <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else if (timeout_hit_s) begin
                        wbm_err_o   <= 1'b1;
                        wbm_dat_o   <= ERR_DATA;
                        timeout_irq <= 1'b1;
                        timeout_adr <= wbs_adr_o;
                        wbs_cyc_o   <= 1'b0;
                        wbs_stb_o   <= 1'b0;
                        state_r     <= ST_DONE;
                    end else begin
                        wait_cnt_r  <= wait_cnt_r + 16'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    wbs_cyc_o <= 1'b0;
                    wbs_stb_o <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_timeout_bridge.sv
// Randomized scoreboard bench for wb_timeout_bridge with a transaction-level reference model.
module tb_wb_timeout_bridge;

    localparam int          T    = 16;
    localparam int          CW   = 2;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;

    logic          clk = 1'b0;
    logic          wb_rst_i = 1'b1;
    logic          wbm_cyc_i = 1'b0, wbm_stb_i = 1'b0, wbm_we_i = 1'b0;
    logic [3:0]    wbm_sel_i = 4'd0;
    logic [31:0]   wbm_adr_i = 32'd0, wbm_dat_i = 32'd0;
    logic [31:0]   wbm_dat_o;
    logic          wbm_ack_o, wbm_err_o;
    logic          wbs_cyc_o, wbs_stb_o, wbs_we_o;
    logic [3:0]    wbs_sel_o;
    logic [31:0]   wbs_adr_o, wbs_dat_o;
    logic [31:0]   wbs_dat_i = 32'd0;
    logic          wbs_ack_i = 1'b0, wbs_err_i = 1'b0;
`ifdef WB_TIMEOUT_CLEAR_EN
    logic          timeout_clr = 1'b0;
`endif
    logic [CW-1:0] timeout_cnt;
    logic [31:0]   timeout_adr;
    logic          timeout_irq;

    wb_timeout_bridge #(.TIMEOUT(T), .ERR_DATA(ERRD), .CNT_W(CW)) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
        .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_we_i(wbm_we_i),
        .wbm_sel_i(wbm_sel_i), .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i),
        .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
        .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
        .wbs_sel_o(wbs_sel_o), .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o),
        .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
`ifdef WB_TIMEOUT_CLEAR_EN
        .timeout_clr(timeout_clr),
`endif
        .timeout_cnt(timeout_cnt), .timeout_adr(timeout_adr), .timeout_irq(timeout_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        int          rise;
        int          dur;
    } req_t;

    typedef struct {
        logic          err;
        logic [31:0]   dat;
        logic          irq;
        int            cyc;
        logic [CW-1:0] cnt;
        logic [31:0]   tadr;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;

    // Reference model state: saturating timeout count, last timeout address, master read data
    logic [CW-1:0] m_cnt  = '0;
    logic [31:0]   m_tadr = 32'd0;
    logic [31:0]   m_dat  = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got an event, expected none", name);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wbm"}, {wbm_ack_o, wbm_err_o, wbm_dat_o}, 64'd0);
        check({tag, "_wbs_ctl"}, {wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o}, 64'd0);
        check({tag, "_wbs_adr_dat"}, {wbs_adr_o, wbs_dat_o}, 64'd0);
        check({tag, "_tmo"}, {timeout_irq, timeout_cnt, timeout_adr}, 64'd0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc_n++;
    end

    // Slave-side monitor: request latency, pass-through fields and strobe length
    initial begin
        logic prev_stb;
        int   run_len;
        req_t cur;
        prev_stb = 1'b0;
        run_len  = 0;
        cur      = '{1'b0, 4'd0, 32'd0, 32'd0, 0, 0};
        forever begin
            @(negedge clk);
            if (wbs_stb_o && !prev_stb) begin
                if (req_q.size() == 0) begin
                    fail("unexpected_req");
                end else begin
                    cur = req_q.pop_front();
                    check("req_latency", 64'(cyc_n), 64'(cur.rise));
                    check("req_fields", {wbs_cyc_o, wbs_we_o, wbs_sel_o, wbs_adr_o},
                          {1'b1, cur.we, cur.sel, cur.adr});
                    check("req_wdata", wbs_dat_o, cur.dat);
                end
                run_len = 1;
            end else if (wbs_stb_o) begin
                run_len++;
            end else if (prev_stb) begin
                check("stb_len", 64'(run_len), 64'(cur.dur));
                check("cyc_drop", wbs_cyc_o, 1'b0);
            end
            prev_stb = wbs_stb_o;
        end
    end

    // Master-side monitor: every response pulse is matched against the scoreboard
    initial forever begin
        rsp_t e;
        @(negedge clk);
        if (wbm_ack_o || wbm_err_o || timeout_irq) begin
            if (rsp_q.size() == 0) begin
                fail("unexpected_rsp");
            end else begin
                e = rsp_q.pop_front();
                check("rsp_kind", {wbm_ack_o, wbm_err_o, timeout_irq}, {!e.err, e.err, e.irq});
                check("rsp_data", wbm_dat_o, e.dat);
                check("rsp_cycle", 64'(cyc_n), 64'(e.cyc));
                check("rsp_cyc_low", wbs_cyc_o, 1'b0);
                check("rsp_tmo", {timeout_cnt, timeout_adr}, {e.cnt, e.tadr});
            end
        end
    end

    // mode: 0 ack, 1 err, 2 ack+err, 3 no response, 4 master abort, 5 reset; d = wait-cycle index
    task automatic run_txn(input int mode, input int d, input logic we_v, input logic [3:0] sel_v,
                           input logic [31:0] adr_v, input logic [31:0] dat_v,
                           input logic [31:0] sdat_v, input logic clr_last);
        int   issue, dur, last;
        req_t r;
        rsp_t s;
        @(negedge clk);
        wbm_cyc_i = 1'b1;
        wbm_stb_i = 1'b1;
        wbm_we_i  = we_v;
        wbm_sel_i = sel_v;
        wbm_adr_i = adr_v;
        wbm_dat_i = dat_v;
        wbs_dat_i = sdat_v;
        issue     = cyc_n;
        dur       = (mode == 3) ? T : d + 1;
        last      = (mode == 3) ? T : d + 1;
        r.we = we_v; r.sel = sel_v; r.adr = adr_v; r.dat = dat_v;
        r.rise = issue + 1; r.dur = dur;
        req_q.push_back(r);
        if (mode <= 3) begin
            if (mode == 3) begin
                if (clr_last) m_cnt = CW'(1'b1);
                else if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + CW'(1'b1);
                m_tadr = adr_v;
                m_dat  = ERRD;
            end else begin
                m_dat = sdat_v;
            end
            s.err = (mode != 0); s.dat = m_dat; s.irq = (mode == 3);
            s.cyc = issue + 1 + dur; s.cnt = m_cnt; s.tadr = m_tadr;
            rsp_q.push_back(s);
        end
        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            if (i == d && mode <= 2) begin
                wbs_ack_i = (mode != 1);
                wbs_err_i = (mode != 0);
            end
            if (i == d && mode >= 4) begin
                wbm_cyc_i = 1'b0;
                wbm_stb_i = 1'b0;
                wb_rst_i  = (mode == 5);
            end
`ifdef WB_TIMEOUT_CLEAR_EN
            if (mode == 3 && clr_last && i == T - 1) timeout_clr = 1'b1;
            if (mode == 3 && i == T) timeout_clr = 1'b0;
`endif
            if (i == last) begin
                wbs_ack_i = 1'b0;
                wbs_err_i = 1'b0;
                wbm_cyc_i = 1'b0;
                wbm_stb_i = 1'b0;
                if (mode == 5) begin
                    wb_rst_i = 1'b0;
                    m_cnt = '0; m_tadr = 32'd0; m_dat = 32'd0;
                    check_zero("mid_reset");
                end
            end
        end
        @(negedge clk);
        check("idle_dat_hold", wbm_dat_o, m_dat);
        check("idle_tmo", {timeout_cnt, timeout_adr}, {m_cnt, m_tadr});
        check("idle_quiet", {wbm_ack_o, wbm_err_o, wbs_cyc_o, timeout_irq}, 64'd0);
    endtask

    initial begin
        int mode, d;
        repeat (3) @(negedge clk);
        check_zero("reset");
        wb_rst_i = 1'b0;

        run_txn(0, 3, 1'b0, 4'hF, 32'h0000_0010, 32'd0, 32'h1234_5678, 1'b0);
        run_txn(0, 1, 1'b1, 4'hF, 32'h0000_0028, 32'hA5A5_0001, 32'h0BAD_F00D, 1'b0);
        run_txn(3, 0, 1'b0, 4'hF, 32'h0000_0400, 32'd0, 32'h1111_2222, 1'b0);
        run_txn(0, T - 1, 1'b0, 4'h3, 32'h0000_0044, 32'd0, 32'hCAFE_0001, 1'b0);
        run_txn(1, T - 1, 1'b0, 4'hC, 32'h0000_0048, 32'd0, 32'hCAFE_0002, 1'b0);
        run_txn(2, 4, 1'b1, 4'h1, 32'h0000_004C, 32'h5555_AAAA, 32'hCAFE_0003, 1'b0);
        run_txn(4, 5, 1'b0, 4'hF, 32'h0000_0050, 32'd0, 32'hCAFE_0004, 1'b0);
        run_txn(5, 5, 1'b1, 4'hF, 32'h0000_0054, 32'h7777_0000, 32'hCAFE_0005, 1'b0);
        for (int k = 0; k < 5; k++)
            run_txn(3, 0, 1'b0, 4'hF, 32'h0000_1000 + 32'(k * 4), 32'd0, 32'hCAFE_0006, 1'b0);

`ifdef WB_TIMEOUT_CLEAR_EN
        @(negedge clk);
        timeout_clr = 1'b1;
        @(negedge clk);
        timeout_clr = 1'b0;
        m_cnt = '0;
        check("clear_tmo", {timeout_cnt, timeout_adr}, {m_cnt, m_tadr});
        run_txn(3, 0, 1'b0, 4'hF, 32'h0000_2000, 32'd0, 32'd0, 1'b0);
        run_txn(3, 0, 1'b0, 4'hF, 32'h0000_2004, 32'd0, 32'd0, 1'b0);
        run_txn(3, 0, 1'b0, 4'hF, 32'h0000_2008, 32'd0, 32'd0, 1'b1);
`endif

        // Slave responses while idle must not reach the master
        @(negedge clk);
        wbs_ack_i = 1'b1;
        wbs_err_i = 1'b1;
        @(negedge clk);
        wbs_ack_i = 1'b0;
        wbs_err_i = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_ignore", {wbm_ack_o, wbm_err_o, wbs_cyc_o, wbm_dat_o}, {3'b000, m_dat});

        for (int k = 0; k < 40; k++) begin
            mode = $urandom_range(0, 5);
            if (mode == 5 && $urandom_range(0, 3) != 0) mode = 0;
            d = $urandom_range(0, T - 1);
            if ($urandom_range(0, 3) == 0) d = T - 1;
            if (mode == 4 && d == T - 1) d = T - 2;
            run_txn(mode, d, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom,
                    $urandom, 1'b0);
        end

        repeat (3) @(negedge clk);
        check("req_q_drained", 64'(req_q.size()), 64'd0);
        check("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
